// File: rtl/pattern_frame_pkg.sv
// Shared types and defaults for the 1011 pattern frame transmitter and its detector.
// The optional BIT_STUFF_EN build adds the STUFF state; the enum carries it in every build.
package pattern_frame_pkg;

  localparam int PAT_W_DEFAULT = 4;
  localparam logic [PAT_W_DEFAULT-1:0] PATTERN_DEFAULT = 4'b1011;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    STUFF,
    GAP
  } tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pattern_stuff_ctl.sv
// History of the last PAT_W-1 transmitted bits and the stuff-needed comparator.
// Only instantiated when BIT_STUFF_EN is defined.
module pattern_stuff_ctl
  import pattern_frame_pkg::*;
#(
  parameter int                PAT_W   = PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0]  PATTERN = PATTERN_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic bit_i,
  output logic stuff_o
);

  localparam int HW = PAT_W - 1;

  logic [HW-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (load_i) begin
      hist_d = (hist_q << 1) | HW'(bit_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // A match means the next bit would complete PATTERN if it equalled PATTERN[0].
  assign stuff_o = (hist_q == PATTERN[PAT_W-1:1]);

endmodule

// File: rtl/pattern_frame_tx.sv
// Serial frame transmitter: preamble, MSB-first payload, then an idle gap.
// Define BIT_STUFF_EN to insert stuff bits so PATTERN never recurs inside the payload.
module pattern_frame_tx
  import pattern_frame_pkg::*;
#(
  parameter int               DATA_W  = 8,
  parameter int               PAT_W   = PAT_W_DEFAULT,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEFAULT,
  parameter int               GAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sequence_out,
  output logic              frame_active,
  output logic              done
);

  localparam int CNT_W = $clog2(max3(PAT_W, DATA_W, GAP) + 1);
  localparam int FRM_W = PAT_W + DATA_W;

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] next_data_cnt;
  logic [FRM_W-1:0] shift_q, shift_d;
  logic             seq_q, seq_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

`ifdef BIT_STUFF_EN
  logic stuff_need;

  pattern_stuff_ctl #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_stuff_ctl (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (active_d),
    .bit_i   (seq_d),
    .stuff_o (stuff_need)
  );
`endif

  // cnt_q holds the bits still to come in the current phase; the GAP state
  // is named through the package because the GAP parameter shadows it here.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    seq_d         = 1'b0;
    active_d      = 1'b0;
    done_d        = 1'b0;
    ready_d       = 1'b0;
    next_data_cnt = (state_q == PREAMBLE) ? CNT_W'(DATA_W - 1) : cnt_q - 1'b1;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (in_valid && ready_q) begin
          state_d  = PREAMBLE;
          shift_d  = {PATTERN, data_in} << 1;
          seq_d    = PATTERN[PAT_W-1];
          active_d = 1'b1;
          ready_d  = 1'b0;
          cnt_d    = CNT_W'(PAT_W - 1);
        end
      end

      PREAMBLE, PAYLOAD: begin
        active_d = 1'b1;
        if (state_q == PAYLOAD && cnt_q == '0) begin
          state_d  = pattern_frame_pkg::GAP;
          cnt_d    = CNT_W'(GAP - 1);
          active_d = 1'b0;
        end else if (state_q == PREAMBLE && cnt_q != '0) begin
          seq_d   = shift_q[FRM_W-1];
          shift_d = shift_q << 1;
          cnt_d   = cnt_q - 1'b1;
`ifdef BIT_STUFF_EN
        end else if (stuff_need) begin
          state_d = STUFF;
          seq_d   = ~PATTERN[0];
          cnt_d   = next_data_cnt;
`endif
        end else begin
          state_d = PAYLOAD;
          seq_d   = shift_q[FRM_W-1];
          shift_d = shift_q << 1;
          cnt_d   = next_data_cnt;
          done_d  = (next_data_cnt == '0);
        end
      end

`ifdef BIT_STUFF_EN
      STUFF: begin
        active_d = 1'b1;
        state_d  = PAYLOAD;
        seq_d    = shift_q[FRM_W-1];
        shift_d  = shift_q << 1;
        done_d   = (cnt_q == '0);
      end
`endif

      pattern_frame_pkg::GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      seq_q    <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      seq_q    <= seq_d;
      active_q <= active_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign sequence_out = seq_q;
  assign frame_active = active_q;
  assign done         = done_q;
  assign in_ready     = ready_q;

endmodule

// File: tb/tb_pattern_frame_tx.sv
// Self-checking bench for pattern_frame_tx: fixed vectors, corner sequences and random words.
// Expected streams follow the BIT_STUFF_EN setting of the build.
module tb_pattern_frame_tx;

  localparam int         DATA_W  = 8;
  localparam int         PAT_W   = 4;
  localparam int         GAP     = 1;
  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         SPACING = PAT_W + DATA_W + GAP + 1;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] data_in  = 8'h00;
  logic       in_ready;
  logic       sequence_out;
  logic       frame_active;
  logic       done;

  pattern_frame_tx #(
    .DATA_W  (DATA_W),
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .GAP     (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sequence_out (sequence_out),
    .frame_active (frame_active),
    .done         (done)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  bit expQ[$];
  bit gotQ[$];

  typedef struct {
    logic [7:0]  data;
    logic [15:0] bits;
    int          len;
  } vec_t;

  vec_t vecs[4];

  task automatic checkVal(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit tailMatches();
    bit m = 1'b1;
    for (int k = 1; k < PAT_W; k++) begin
      if (expQ.size() < k) m = 1'b0;
      else if (expQ[expQ.size() - k] != PATTERN[k]) m = 1'b0;
    end
    return m;
  endfunction

  // Reference stream: preamble, then data MSB first, with a stuff bit whenever
  // the last PAT_W-1 bits already spell the head of PATTERN.
  task automatic buildExpected(input logic [7:0] word);
    expQ.delete();
    for (int p = PAT_W - 1; p >= 0; p--) expQ.push_back(PATTERN[p]);
    for (int d = DATA_W - 1; d >= 0; d--) begin
`ifdef BIT_STUFF_EN
      if (tailMatches()) expQ.push_back(~PATTERN[0]);
`endif
      expQ.push_back(word[d]);
    end
  endtask

  function automatic int countPattern(input bit useGot, output int firstEnd);
    bit q[$];
    int n = 0;
    bit hit;
    if (useGot) q = gotQ;
    else q = expQ;
    firstEnd = -1;
    for (int i = PAT_W - 1; i < q.size(); i++) begin
      hit = 1'b1;
      for (int j = 0; j < PAT_W; j++)
        if (q[i - PAT_W + 1 + j] != PATTERN[PAT_W - 1 - j]) hit = 1'b0;
      if (hit) begin
        if (firstEnd < 0) firstEnd = i;
        n++;
      end
    end
    return n;
  endfunction

  task automatic applyStimulus(input logic [7:0] word);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkVal("accept timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    data_in  = word;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = 8'($urandom);
  endtask

  task automatic checkOutput(input int glitchAt, input string tag);
    gotQ.delete();
    for (int i = 0; i < expQ.size(); i++) begin
      @(negedge clk);
      gotQ.push_back(sequence_out);
      checkVal($sformatf("%s seq bit%0d", tag, i), int'(sequence_out), int'(expQ[i]));
      checkVal($sformatf("%s active bit%0d", tag, i), int'(frame_active), 1);
      checkVal($sformatf("%s done bit%0d", tag, i), int'(done), (i == expQ.size() - 1) ? 1 : 0);
      checkVal($sformatf("%s ready bit%0d", tag, i), int'(in_ready), 0);
      if (i == glitchAt) begin
        in_valid = 1'b1;
        data_in  = 8'h33;
      end else begin
        in_valid = 1'b0;
      end
    end
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checkVal($sformatf("%s gap seq", tag), int'(sequence_out), 0);
      checkVal($sformatf("%s gap active", tag), int'(frame_active), 0);
      checkVal($sformatf("%s gap done", tag), int'(done), 0);
      checkVal($sformatf("%s gap ready", tag), int'(in_ready), 0);
    end
    @(negedge clk);
    checkVal($sformatf("%s idle ready", tag), int'(in_ready), 1);
    checkVal($sformatf("%s idle seq", tag), int'(sequence_out), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit b2bExp[$];
    bit stream[$];
    bit readyH[$];
    int acc[2];
    int nAcc;
    int errs;
    int ones;
    int cnt;
    int firstEnd;
    int expCnt;
    int dummy;
    logic [7:0] loopWords[3];
    logic [7:0] w;

    vecs[0] = '{data: 8'h5A, bits: 16'h0000, len: 12};
    vecs[1] = '{data: 8'hB0, bits: 16'h0000, len: 12};
    vecs[2] = '{data: 8'hFF, bits: 16'b1011_1111_1111, len: 12};
    vecs[3] = '{data: 8'h00, bits: 16'b1011_0000_0000, len: 12};
`ifdef BIT_STUFF_EN
    vecs[0].bits = 16'b10_1101_0011_0100; vecs[0].len = 14;
    vecs[1].bits = 16'b10_1110_1010_0000; vecs[1].len = 14;
`else
    vecs[0].bits = 16'b1011_0101_1010;
    vecs[1].bits = 16'b1011_1011_0000;
`endif

    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("reset seq", int'(sequence_out), 0);
    checkVal("reset active", int'(frame_active), 0);
    checkVal("reset done", int'(done), 0);
    checkVal("reset ready", int'(in_ready), 1);
    rst = 1'b1;

    for (int v = 0; v < 4; v++) begin
      expQ.delete();
      for (int i = 0; i < vecs[v].len; i++) expQ.push_back(vecs[v].bits[vecs[v].len - 1 - i]);
      applyStimulus(vecs[v].data);
      checkOutput(-1, $sformatf("vec%0d", v));
    end

    // A request while busy must be dropped, never queued.
    buildExpected(8'hC3);
    applyStimulus(8'hC3);
    checkOutput(6, "glitch");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkVal("glitch ignored seq", int'(sequence_out), 0);
      checkVal("glitch ignored active", int'(frame_active), 0);
    end

    buildExpected(8'hFF);
    b2bExp = expQ;
    for (int g = 0; g < GAP + 1; g++) b2bExp.push_back(1'b0);
    buildExpected(8'h00);
    foreach (expQ[i]) b2bExp.push_back(expQ[i]);
    in_valid = 1'b1;
    data_in  = 8'hFF;
    nAcc     = 0;
    for (int c = 0; c < 40; c++) begin
      if (nAcc == 1) data_in = 8'h00;
      if (nAcc == 2) in_valid = 1'b0;
      stream.push_back(sequence_out);
      readyH.push_back(in_ready);
      if (in_valid && in_ready && nAcc < 2) begin
        acc[nAcc] = c;
        nAcc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkVal("b2b accept count", nAcc, 2);
    if (nAcc == 2 && acc[0] + SPACING + PAT_W + DATA_W + GAP + 1 < readyH.size()) begin
      checkVal("b2b spacing", acc[1] - acc[0], SPACING);
      errs = 0;
      for (int k = 0; k < b2bExp.size(); k++)
        if (acc[0] + 1 + k < stream.size() && stream[acc[0] + 1 + k] != b2bExp[k]) errs++;
      checkVal("b2b stream mismatches", errs, 0);
      ones = 0;
      for (int c = acc[0] + 1; c < acc[1]; c++) ones += int'(readyH[c]);
      for (int c = acc[1] + 1; c <= acc[1] + PAT_W + DATA_W + GAP; c++) ones += int'(readyH[c]);
      checkVal("b2b ready high while busy", ones, 0);
      checkVal("b2b ready after frame", int'(readyH[acc[1] + PAT_W + DATA_W + GAP + 1]), 1);
    end else begin
      checkVal("b2b accept timing", 0, 1);
    end

    // Asynchronous reset in the middle of the payload.
    applyStimulus(8'hAA);
    repeat (PAT_W + 5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkVal("midreset seq", int'(sequence_out), 0);
    checkVal("midreset active", int'(frame_active), 0);
    checkVal("midreset ready", int'(in_ready), 1);
    checkVal("midreset done", int'(done), 0);
    repeat (2) begin
      @(negedge clk);
      checkVal("midreset held done", int'(done), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("post-reset seq", int'(sequence_out), 0);
      checkVal("post-reset active", int'(frame_active), 0);
      checkVal("post-reset done", int'(done), 0);
    end
    buildExpected(8'h5A);
    applyStimulus(8'h5A);
    checkOutput(-1, "post-reset frame");

    loopWords[0] = 8'hB0;
    loopWords[1] = 8'h5B;
    loopWords[2] = 8'h0B;
    for (int f = 0; f < 3; f++) begin
      buildExpected(loopWords[f]);
      applyStimulus(loopWords[f]);
      checkOutput(-1, $sformatf("loop%0d", f));
`ifdef BIT_STUFF_EN
      expCnt = 1;
`else
      expCnt = countPattern(1'b0, dummy);
`endif
      cnt = countPattern(1'b1, firstEnd);
      checkVal($sformatf("loop%0d detections", f), cnt, expCnt);
      checkVal($sformatf("loop%0d first detect end", f), firstEnd, PAT_W - 1);
    end

    for (int r = 0; r < 20; r++) begin
      w = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      buildExpected(w);
      applyStimulus(w);
      checkOutput(-1, $sformatf("rand%0d_%02h", r, w));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
